position_bcd_display: RTL and testbench

Downstream consumer of the bouncing-LED physics stage. Takes the signed q8.24 position word on each time-step strobe and converts it to a four-digit decimal reading in hundredths of a unit, formatted "DD.DD". Saturation, truncation and negative clamping are defined below. The conversion is a sequential shift-add-3 (double-dabble) engine. The result drives four active-low seven-segment displays (HEX3..HEX0), replacing the raw hex-nibble display of the position byte.

---
 rtl/position_bcd_display.sv | 143 ++++++++++++++
 tb/tb_position_bcd_display.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/position_bcd_display.sv
// Converts a signed q8.24 position to a "DD.DD" hundredths reading on four active-low
// seven-segment displays. Define BCD_LEADING_ZERO_BLANK_EN to blank HEX3 when the tens digit is 0.
module position_bcd_display #(
  parameter int unsigned SAT_VALUE = 9999
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        Sample,
  input  logic [31:0] Value,
  output logic        Busy,
  output logic        Done,
  output logic [7:0]  HEX0,
  output logic [7:0]  HEX1,
  output logic [7:0]  HEX2,
  output logic [7:0]  HEX3
);

  localparam int unsigned VAL_W  = 32;
  localparam int unsigned PROD_W = 40;
  localparam int unsigned BIN_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ITER   = 14;
  localparam int unsigned FRAC_W = 24;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

  state_t             state, state_next;
  logic [VAL_W-1:0]   value_q, value_next;
  logic [BIN_W-1:0]   bin_q, bin_next;
  logic [BCD_W-1:0]   bcd_q, bcd_next, bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic [7:0]         hex0_next, hex1_next, hex2_next, hex3_next;
  logic               done_next, busy_next;
  logic [PROD_W-1:0]  prod;
  logic [15:0]        n_full;
  logic [BIN_W-1:0]   n_sat;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      value_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      HEX0    <= 8'hFF;
      HEX1    <= 8'hFF;
      HEX2    <= 8'hFF;
      HEX3    <= 8'hFF;
    end else begin
      state   <= state_next;
      value_q <= value_next;
      bin_q   <= bin_next;
      bcd_q   <= bcd_next;
      cnt_q   <= cnt_next;
      Busy    <= busy_next;
      Done    <= done_next;
      HEX0    <= hex0_next;
      HEX1    <= hex1_next;
      HEX2    <= hex2_next;
      HEX3    <= hex3_next;
    end
  end

  // Next-state, scaling, double-dabble step and segment encoding
  always_comb begin
    state_next = state;
    value_next = value_q;
    bin_next   = bin_q;
    bcd_next   = bcd_q;
    cnt_next   = cnt_q;
    hex0_next  = HEX0;
    hex1_next  = HEX1;
    hex2_next  = HEX2;
    hex3_next  = HEX3;
    done_next  = 1'b0;

    // V*100 without a multiplier; the 40-bit width holds the full positive range
    prod   = (PROD_W'(value_q) << 6) + (PROD_W'(value_q) << 5) + (PROD_W'(value_q) << 2);
    n_full = 16'(prod >> FRAC_W);
    n_sat  = (32'(n_full) > SAT_VALUE) ? BIN_W'(SAT_VALUE) : BIN_W'(n_full);

    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    case (state)
      IDLE: begin
        if (Sample) begin
          value_next = Value;
          state_next = LOAD;
        end
      end
      LOAD: begin
        bin_next   = value_q[VAL_W-1] ? '0 : n_sat;
        bcd_next   = '0;
        cnt_next   = CNT_W'(ITER);
        state_next = SHIFT;
      end
      SHIFT: begin
        {bcd_next, bin_next} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_next = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_next = UPDATE;
      end
      UPDATE: begin
        hex3_next = seg_code(bcd_q[15:12]);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        if (bcd_q[15:12] == 4'd0) hex3_next = 8'hFF;
`else
`endif
        hex2_next  = seg_code(bcd_q[11:8]) & 8'h7F;
        hex1_next  = seg_code(bcd_q[7:4]);
        hex0_next  = seg_code(bcd_q[3:0]);
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_position_bcd_display.sv
// Directed self-checking bench for position_bcd_display (honours BCD_LEADING_ZERO_BLANK_EN).
module tb_position_bcd_display;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        Sample;
  logic [31:0] Value;
  logic        Busy, Done;
  logic [7:0]  HEX0, HEX1, HEX2, HEX3;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int last_done = 0;
  int t1 = 0;
  int done_cnt = 0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  position_bcd_display #(.SAT_VALUE(9999)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .Sample  (Sample),
    .Value   (Value),
    .Busy    (Busy),
    .Done    (Done),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One full conversion: accept at edge k, result expected right after edge k+16
  task automatic convert(input logic [31:0] v, input logic [31:0] exp, input string tag);
    logic [31:0] prev;
    logic [31:0] e;
    prev = {HEX3, HEX2, HEX1, HEX0};
    e = exp;
    if (BLANK && e[31:24] == 8'hC0) e[31:24] = 8'hFF;
    Sample = 1'b1;
    Value  = v;
    step();
    Sample = 1'b0;
    Value  = $urandom;
    chk({tag, "_busy_k"}, 32'(Busy), 32'(1'b1));
    chk({tag, "_done_k"}, 32'(Done), 32'(1'b0));
    repeat (15) step();
    chk({tag, "_hold_k15"}, {HEX3, HEX2, HEX1, HEX0}, prev);
    chk({tag, "_done_k15"}, 32'(Done), 32'(1'b0));
    chk({tag, "_busy_k15"}, 32'(Busy), 32'(1'b1));
    step();
    chk({tag, "_hex"}, {HEX3, HEX2, HEX1, HEX0}, e);
    chk({tag, "_done_k16"}, 32'(Done), 32'(1'b1));
    chk({tag, "_busy_k16"}, 32'(Busy), 32'(1'b0));
    last_done = cyc;
  endtask

  initial begin
    RESET_N = 1'b0;
    Sample  = 1'b0;
    Value   = 32'h0;
    repeat (2) step();
    chk("reset_hex", {HEX3, HEX2, HEX1, HEX0}, 32'hFFFF_FFFF);
    chk("reset_busy", 32'(Busy), 32'(1'b0));
    chk("reset_done", 32'(Done), 32'(1'b0));
    RESET_N = 1'b1;
    step();
    chk("idle_hex", {HEX3, HEX2, HEX1, HEX0}, 32'hFFFF_FFFF);

    convert(32'h0180_0000, 32'hC079_92C0, "one_half");
    step();
    chk("done_fall", 32'(Done), 32'(1'b0));
    convert(32'h0005_1EB8, 32'hC040_C0F9, "trunc");
    convert(32'hFF00_0000, 32'hC040_C0C0, "neg_clamp");
    convert(32'h7F00_0000, 32'h9010_9090, "saturate");

    // Second strobe during conversion must be dropped
    done_cnt = 0;
    Sample = 1'b1;
    Value  = 32'h0200_0000;
    step();
    Sample = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (Done) done_cnt++;
      if (i == 4) begin
        Sample = 1'b1;
        Value  = 32'h0500_0000;
      end
      if (i == 5) Sample = 1'b0;
    end
    chk("drop_hex", {HEX3, HEX2, HEX1, HEX0}, BLANK ? 32'hFF24_C0C0 : 32'hC024_C0C0);
    chk("drop_busy", 32'(Busy), 32'(1'b0));
    repeat (20) begin
      step();
      if (Done) done_cnt++;
    end
    chk("drop_done_cnt", 32'(done_cnt), 32'(1));

    // Reset asserted just before edge k+8
    Sample = 1'b1;
    Value  = 32'h0300_0000;
    step();
    Sample = 1'b0;
    repeat (7) step();
    RESET_N = 1'b0;
    #1;
    chk("midrst_hex", {HEX3, HEX2, HEX1, HEX0}, 32'hFFFF_FFFF);
    chk("midrst_busy", 32'(Busy), 32'(1'b0));
    done_cnt = 0;
    repeat (2) begin
      step();
      if (Done) done_cnt++;
    end
    RESET_N = 1'b1;
    repeat (10) begin
      step();
      if (Done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'(0));
    chk("midrst_hex_after", {HEX3, HEX2, HEX1, HEX0}, 32'hFFFF_FFFF);
    convert(32'h0400_0000, 32'hC019_C0C0, "post_rst");

    // Back-to-back: second accept at edge k+17
    step();
    convert(32'h0A00_0000, 32'hF940_C0C0, "b2b_a");
    t1 = last_done;
    convert(32'h6380_0000, 32'h9010_92C0, "b2b_b");
    chk("b2b_spacing", 32'(last_done - t1), 32'(17));
    step();
    chk("b2b_done_fall", 32'(Done), 32'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
